instr_dispatcher: RTL and testbench
===================================

# instr_dispatcher

Queued, parametrised instruction dispatcher for the TPU control path. It sits between the instruction fetch stage and the NUM_UNITS execution units (weight, matrix and activation by default). It buffers incoming instructions in a QUEUE_DEPTH-entry FIFO, decodes the head into a one-hot unit-issue mask, and issues it once every unit it depends on is idle. Synchronize instructions are held until all unit resources drain.

## Interface
- NUM_UNITS, 3: number of execution units. Legal range 1..MAX_UNITS.
- QUEUE_DEPTH, 4: instruction FIFO entries. Must be a power of two, ≥2.
- clk  in  1  clock
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- enable  in  1  global run enable. Low freezes the block.
- instr  in  instr_type  incoming instruction.
- instr_enable  in  1  instr valid.
- busy  out  1  queue full. Upstream must hold instr/instr_enable while high.
- idle  out  1  queue empty, no lockout pending, no output pulse this cycle.
- unit_busy  in  NUM_UNITS  per-unit busy.
- unit_resource_busy  in  NUM_UNITS  per-unit resource busy; used by sync only.
- unit_instr  out  instr_type  broadcast issued instruction; registered.
- unit_instr_enable  out  NUM_UNITS  one-cycle issue strobe per unit; registered.
- synchronize  out  1  one-cycle sync pulse; registered.

## Operation
- Accept: when instr_enable && enable && !busy, instr is pushed at the clock edge. busy = (count == QUEUE_DEPTH), taken from registered count. When full, nothing is pushed, even if a pop happens in the same cycle.
- Decode uses tpu_pkg::unit_decode(opcode), which returns an issue mask and a dependency mask. Priority order:
  - 8'hFF → sync.
  - opcode[7] → issue unit2, depends on {1,2}.
  - opcode[5] → issue unit1, depends on {1}.
  - opcode[3] → issue unit0, depends on {0}.
  - Otherwise NOP (both masks zero).
  - Mask bits ≥ NUM_UNITS are truncated.
- FSM: S_EMPTY → S_HEAD when count > 0. S_HEAD → S_SYNC when the head is sync. S_SYNC → S_HEAD or S_EMPTY after the sync pulse.
- Issue in S_HEAD: the head issues when ((unit_busy | lockout) & dep_mask) == 0. On issue:
  - unit_instr ← head and unit_instr_enable ← issue_mask, both on the next edge.
  - The head is popped.
  - lockout ← issue_mask for exactly one cycle. This covers the cycle before the unit raises its busy.
- NOP: popped in one cycle with no strobe.
- Sync: wait until unit_resource_busy == 0 and lockout == 0. Then synchronize ← 1 for one cycle and pop.
- enable low: no push, no pop, no issue, FSM and queue held. Registered strobes go to 0 on the next edge; unit_instr holds its value.
- Reset: queue empty, S_EMPTY, lockout 0, unit_instr_enable 0, synchronize 0, unit_instr = INIT_INSTR, busy 0, idle 1. Reset mid-operation discards all queued instructions and any pending strobe.
- Pointers wrap modulo QUEUE_DEPTH. Push and pop in the same cycle keep count unchanged.

## Timing
- Push at edge E0. The head is evaluated in the cycle after E0. Strobe is high in the cycle after E1. Minimum latency is 2 cycles from the accept cycle to unit_instr_enable.
- Throughput is one issue or pop per cycle. Back-to-back instructions to the same unit are separated by at least 2 cycles because of the lockout.
- All strobes last exactly one cycle. Sync pulse is at least 1 cycle after the last resource_busy deasserts.

## Configuration
- INSTR_DISPATCHER_STATS_EN defined:
  - Adds outputs stall_cycles[31:0], counting cycles in S_HEAD/S_SYNC with a valid head not issued while enable=1.
  - Adds issued_count[31:0], counting non-NOP pops.
  - Both counters saturate, reset to 0 and freeze while enable=0.
- Undefined: the ports and counters are absent.

## Structure
- tpu_pkg holds: instr_type, INIT_INSTR, OPCODE_SYNC = 8'hFF, MAX_UNITS = 8, and the function unit_decode(opcode) returning issue/dependency masks of width MAX_UNITS.
- Sub-module instr_fifo (parameters WIDTH via $bits(instr_type), DEPTH). Interface: push/pop/full/empty/count, head output combinational from storage.

## Test plan
- Single opcode 8'h08, all units idle → unit_instr_enable = 3'b001 for one cycle, 2 cycles after accept. unit_instr.opcode = 8'h08.
- Opcode 8'h80 with unit_busy = 3'b010 held 5 cycles → no strobe until 1 cycle after unit_busy clears. Then strobe 3'b100.
- Two 8'h20 back-to-back, unit_busy stuck 0 → strobes 3'b010 exactly 2 cycles apart.
- 8'hFF with unit_resource_busy = 3'b001 for 4 cycles → synchronize pulses once, only after it clears. No unit strobe.
- Push 5 instructions with QUEUE_DEPTH=4 and unit0 busy → busy high after the 4th accept. 5th held; accepted after the first pop. Order preserved, including pointer wrap.
- rst asserted with 3 queued instructions, then NOP 8'h00 → no strobes, idle=1, unit_instr = INIT_INSTR. NOP is popped with no strobe.

Source files
------------

// File: rtl/tpu_pkg.sv
// Shared TPU control-path types: instruction format, sync opcode and unit decode.
package tpu_pkg;

    localparam int unsigned MAX_UNITS   = 8;
    localparam int unsigned OPCODE_W    = 8;
    localparam int unsigned FLAGS_W     = 8;
    localparam int unsigned OPERAND_W   = 16;

    localparam logic [OPCODE_W-1:0] OPCODE_SYNC = 8'hFF;

    typedef struct packed {
        logic [OPCODE_W-1:0]  opcode;
        logic [FLAGS_W-1:0]   flags;
        logic [OPERAND_W-1:0] operand;
    } instr_type;

    localparam instr_type INIT_INSTR = '{opcode: 8'h00, flags: 8'h00, operand: 16'hC0DE};

    typedef struct packed {
        logic [MAX_UNITS-1:0] issue;
        logic [MAX_UNITS-1:0] dep;
    } unit_decode_t;

    // Opcode to issue/dependency masks; sync and NOP return empty masks.
    function automatic unit_decode_t unit_decode(input logic [OPCODE_W-1:0] opcode);
        unit_decode_t d;
        d.issue = '0;
        d.dep   = '0;
        if (opcode != OPCODE_SYNC) begin
            if (opcode[7]) begin
                d.issue[2] = 1'b1;
                d.dep[1]   = 1'b1;
                d.dep[2]   = 1'b1;
            end else if (opcode[5]) begin
                d.issue[1] = 1'b1;
                d.dep[1]   = 1'b1;
            end else if (opcode[3]) begin
                d.issue[0] = 1'b1;
                d.dep[0]   = 1'b1;
            end
        end
        return d;
    endfunction

endpackage

// File: rtl/instr_dispatcher_if.sv
// Fetch-side and execution-unit-side signals of the instruction dispatcher.
interface instr_dispatcher_if #(
    parameter int unsigned NUM_UNITS = 3
);
    import tpu_pkg::*;

    logic                 enable;
    instr_type            instr;
    logic                 instr_enable;
    logic                 busy;
    logic                 idle;
    logic [NUM_UNITS-1:0] unit_busy;
    logic [NUM_UNITS-1:0] unit_resource_busy;
    instr_type            unit_instr;
    logic [NUM_UNITS-1:0] unit_instr_enable;
    logic                 synchronize;

    modport master (
        output enable, instr, instr_enable, unit_busy, unit_resource_busy,
        input  busy, idle, unit_instr, unit_instr_enable, synchronize
    );

    modport slave (
        input  enable, instr, instr_enable, unit_busy, unit_resource_busy,
        output busy, idle, unit_instr, unit_instr_enable, synchronize
    );

endinterface

// File: rtl/instr_fifo.sv
// Power-of-two instruction FIFO; head is read combinationally from storage.
module instr_fifo #(
    parameter  int unsigned WIDTH = 32,
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage write; no reset needed since count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/instr_dispatcher.sv
// Queued instruction dispatcher: buffers fetched instructions and issues the
// head to its execution unit once its dependencies are idle; sync waits for
// all unit resources to drain. Optional counters: INSTR_DISPATCHER_STATS_EN.
module instr_dispatcher
    import tpu_pkg::*;
#(
    parameter int unsigned NUM_UNITS   = 3,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef INSTR_DISPATCHER_STATS_EN
    output logic [31:0] stall_cycles,
    output logic [31:0] issued_count,
`endif
    instr_dispatcher_if.slave bus
);

    localparam int unsigned CNT_W = ((QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1) + 1;

    if (NUM_UNITS < 1 || NUM_UNITS > MAX_UNITS) begin : g_bad_units
        $error("instr_dispatcher: NUM_UNITS out of range");
    end
    if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_dispatcher: QUEUE_DEPTH must be a power of two >= 2");
    end

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_HEAD  = 2'd1,
        S_SYNC  = 2'd2
    } state_t;

    state_t               state;
    logic [NUM_UNITS-1:0] lockout;
    instr_type            unit_instr_q;
    logic [NUM_UNITS-1:0] unit_instr_enable_q;
    logic                 synchronize_q;

    instr_type            head;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CNT_W-1:0]     fifo_count;

    unit_decode_t         decode;
    logic                 unused_decode_bits;
    logic [NUM_UNITS-1:0] issue_mask;
    logic [NUM_UNITS-1:0] dep_mask;
    logic                 head_is_sync;
    logic                 head_is_nop;
    logic                 push_c;
    logic                 pop_c;
    logic                 issue_c;
    logic                 sync_fire_c;
    logic                 last_entry_c;

    assign push_c = bus.instr_enable && bus.enable && !fifo_full;

    instr_fifo #(
        .WIDTH ($bits(instr_type)),
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_c),
        .din   (bus.instr),
        .pop   (pop_c),
        .head  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Head decode, truncated to the configured unit count.
    always_comb begin
        decode       = unit_decode(head.opcode);
        issue_mask   = NUM_UNITS'(decode.issue);
        dep_mask     = NUM_UNITS'(decode.dep);
        head_is_sync = (head.opcode == OPCODE_SYNC);
        head_is_nop  = !head_is_sync && (issue_mask == '0);
    end

    assign unused_decode_bits = ^{decode.issue, decode.dep};

    // Issue/pop decision for the current head.
    always_comb begin
        issue_c     = 1'b0;
        sync_fire_c = 1'b0;
        pop_c       = 1'b0;
        if (bus.enable && !fifo_empty) begin
            case (state)
                S_HEAD: begin
                    if (!head_is_sync) begin
                        if (head_is_nop) begin
                            pop_c = 1'b1;
                        end else if (((bus.unit_busy | lockout) & dep_mask) == '0) begin
                            issue_c = 1'b1;
                            pop_c   = 1'b1;
                        end
                    end
                end
                S_SYNC: begin
                    if (bus.unit_resource_busy == '0 && lockout == '0) begin
                        sync_fire_c = 1'b1;
                        pop_c       = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign last_entry_c = pop_c && !push_c && (fifo_count == CNT_W'(1));

    // Dispatch FSM with registered strobes, broadcast instruction and lockout.
    always_ff @(posedge clk) begin
        if (rst) begin
            state               <= S_EMPTY;
            lockout             <= '0;
            unit_instr_q        <= INIT_INSTR;
            unit_instr_enable_q <= '0;
            synchronize_q       <= 1'b0;
        end else if (!bus.enable) begin
            lockout             <= '0;
            unit_instr_enable_q <= '0;
            synchronize_q       <= 1'b0;
        end else begin
            lockout             <= '0;
            unit_instr_enable_q <= '0;
            synchronize_q       <= sync_fire_c;
            if (issue_c) begin
                unit_instr_q        <= head;
                unit_instr_enable_q <= issue_mask;
                lockout             <= issue_mask;
            end
            case (state)
                S_EMPTY: begin
                    if (push_c) begin
                        state <= S_HEAD;
                    end
                end
                S_HEAD: begin
                    if (!fifo_empty && head_is_sync) begin
                        state <= S_SYNC;
                    end else if (last_entry_c) begin
                        state <= S_EMPTY;
                    end
                end
                S_SYNC: begin
                    if (sync_fire_c) begin
                        state <= last_entry_c ? S_EMPTY : S_HEAD;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

`ifdef INSTR_DISPATCHER_STATS_EN
    logic stall_c;
    assign stall_c = bus.enable && !fifo_empty && !pop_c &&
                     (state == S_HEAD || state == S_SYNC);

    // Saturating stall and issue counters, frozen while disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles <= '0;
            issued_count <= '0;
        end else if (bus.enable) begin
            if (stall_c && stall_cycles != '1) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if ((issue_c || sync_fire_c) && issued_count != '1) begin
                issued_count <= issued_count + 32'd1;
            end
        end
    end
`endif

    assign bus.busy              = fifo_full;
    assign bus.idle              = fifo_empty && (lockout == '0) &&
                                   (unit_instr_enable_q == '0) && !synchronize_q;
    assign bus.unit_instr        = unit_instr_q;
    assign bus.unit_instr_enable = unit_instr_enable_q;
    assign bus.synchronize       = synchronize_q;

endmodule

// File: tb/tb_instr_dispatcher.sv
// Directed bench for instr_dispatcher with a scoreboard of expected issues/syncs.
module tb_instr_dispatcher;
    import tpu_pkg::*;

    typedef struct {
        logic [2:0] mask;
        logic       sync;
        instr_type  instr;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_asserts = 0;
    int   n_fail = 0;

    exp_t sb[$];
    int   strobe_edges[$];
    int   sync_edges[$];

`ifdef INSTR_DISPATCHER_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] issued_count;
`endif

    instr_dispatcher_if #(.NUM_UNITS(3)) bus ();

    instr_dispatcher #(
        .NUM_UNITS   (3),
        .QUEUE_DEPTH (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef INSTR_DISPATCHER_STATS_EN
        .stall_cycles (stall_cycles),
        .issued_count (issued_count),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic instr_type mk(input logic [7:0] op, input logic [15:0] opnd);
        instr_type t;
        t.opcode  = op;
        t.flags   = 8'h5A;
        t.operand = opnd;
        return t;
    endfunction

    function automatic void expect_issue(input logic [2:0] mask, input instr_type ins);
        exp_t e;
        e.mask  = mask;
        e.sync  = 1'b0;
        e.instr = ins;
        sb.push_back(e);
    endfunction

    function automatic void expect_sync();
        exp_t e;
        e.mask  = 3'b000;
        e.sync  = 1'b1;
        e.instr = INIT_INSTR;
        sb.push_back(e);
    endfunction

    // Push one instruction, holding it until the queue accepts; acc is the accept edge.
    task automatic push_one(input instr_type ins, output int acc);
        bit ok;
        ok = 1'b0;
        bus.instr        = ins;
        bus.instr_enable = 1'b1;
        for (int i = 0; i < 40 && !ok; i++) begin
            if (!bus.busy) ok = 1'b1;
            tick();
        end
        bus.instr_enable = 1'b0;
        acc = cyc;
        check("push_accepted", 32'(ok), 32'd1);
    endtask

    // Output monitor: every strobe or sync pulse is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst && (bus.unit_instr_enable != 3'b000 || bus.synchronize)) begin
            if (bus.unit_instr_enable != 3'b000) strobe_edges.push_back(cyc);
            if (bus.synchronize) sync_edges.push_back(cyc);
            if (sb.size() == 0) begin
                check("unexpected_strobe", 32'(bus.unit_instr_enable), 32'd0);
                check("unexpected_sync", 32'(bus.synchronize), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_mask", 32'(bus.unit_instr_enable), 32'(e.mask));
                check("sb_sync", 32'(bus.synchronize), 32'(e.sync));
                if (!e.sync) check("sb_instr", 32'(bus.unit_instr), 32'(e.instr));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, acc2, clr, en;
        instr_type t;

        bus.enable             = 1'b1;
        bus.instr              = '0;
        bus.instr_enable       = 1'b0;
        bus.unit_busy          = 3'b000;
        bus.unit_resource_busy = 3'b000;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_idle", 32'(bus.idle), 32'd1);
        check("rst_unit_instr", 32'(bus.unit_instr), 32'(INIT_INSTR));
        check("rst_strobe", 32'(bus.unit_instr_enable), 32'd0);
        check("rst_sync", 32'(bus.synchronize), 32'd0);

        // Single unit0 instruction, all idle: strobe set on the edge after accept
        t = mk(8'h08, 16'h1111);
        expect_issue(3'b001, t);
        push_one(t, acc);
        repeat (5) tick();
        check("s1_count", 32'(strobe_edges.size()), 32'd1);
        if (strobe_edges.size() > 0) check("s1_latency", 32'(strobe_edges[0] - acc), 32'd1);
        check("s1_idle", 32'(bus.idle), 32'd1);
        strobe_edges.delete();

        // Unit2 instruction blocked by busy dependency unit1
        bus.unit_busy = 3'b010;
        t = mk(8'h80, 16'h2222);
        expect_issue(3'b100, t);
        push_one(t, acc);
        repeat (5) tick();
        check("s2_held", 32'(strobe_edges.size()), 32'd0);
        check("s2_not_idle", 32'(bus.idle), 32'd0);
        bus.unit_busy = 3'b000;
        clr = cyc;
        repeat (4) tick();
        check("s2_count", 32'(strobe_edges.size()), 32'd1);
        if (strobe_edges.size() > 0) check("s2_release", 32'(strobe_edges[0] - clr), 32'd1);
        strobe_edges.delete();

        // Back-to-back unit1 instructions separated by the lockout
        t = mk(8'h20, 16'h3301);
        expect_issue(3'b010, t);
        push_one(t, acc);
        t = mk(8'h20, 16'h3302);
        expect_issue(3'b010, t);
        push_one(t, acc2);
        repeat (6) tick();
        check("s3_count", 32'(strobe_edges.size()), 32'd2);
        if (strobe_edges.size() > 1) begin
            check("s3_first", 32'(strobe_edges[0] - acc), 32'd1);
            check("s3_gap", 32'(strobe_edges[1] - strobe_edges[0]), 32'd2);
        end
        strobe_edges.delete();

        // Sync waits for resource busy to clear
        bus.unit_resource_busy = 3'b001;
        expect_sync();
        push_one(mk(8'hFF, 16'h4444), acc);
        repeat (4) tick();
        check("s4_held", 32'(sync_edges.size()), 32'd0);
        bus.unit_resource_busy = 3'b000;
        clr = cyc;
        repeat (4) tick();
        check("s4_count", 32'(sync_edges.size()), 32'd1);
        if (sync_edges.size() > 0)
            check("s4_window", 32'((sync_edges[0] > clr) && (sync_edges[0] <= clr + 2)), 32'd1);
        check("s4_no_strobe", 32'(strobe_edges.size()), 32'd0);
        sync_edges.delete();

        // Enable low freezes a ready head
        bus.unit_busy = 3'b001;
        t = mk(8'h08, 16'h0E0E);
        expect_issue(3'b001, t);
        push_one(t, acc);
        bus.enable    = 1'b0;
        bus.unit_busy = 3'b000;
        repeat (3) tick();
        check("en_frozen", 32'(strobe_edges.size()), 32'd0);
        bus.enable = 1'b1;
        en = cyc;
        repeat (3) tick();
        check("en_count", 32'(strobe_edges.size()), 32'd1);
        if (strobe_edges.size() > 0) check("en_release", 32'(strobe_edges[0] - en), 32'd1);
        strobe_edges.delete();

        // Fill the queue with unit0 blocked, fifth held until the first pop (pointers wrap)
        bus.unit_busy = 3'b001;
        for (int i = 0; i < 4; i++) begin
            t = mk(8'h08, 16'h5000 + 16'(i));
            expect_issue(3'b001, t);
            push_one(t, acc);
        end
        check("s5_full", 32'(bus.busy), 32'd1);
        t = mk(8'h08, 16'h5004);
        expect_issue(3'b001, t);
        bus.instr        = t;
        bus.instr_enable = 1'b1;
        repeat (3) tick();
        check("s5_still_full", 32'(bus.busy), 32'd1);
        check("s5_held", 32'(strobe_edges.size()), 32'd0);
        bus.unit_busy = 3'b000;
        push_one(t, acc);
        repeat (14) tick();
        check("s5_count", 32'(strobe_edges.size()), 32'd5);
        if (strobe_edges.size() > 4) begin
            check("s5_accept_after_pop", 32'(acc - strobe_edges[0]), 32'd1);
            check("s5_spacing", 32'(strobe_edges[4] - strobe_edges[0]), 32'd8);
        end
        check("s5_not_full", 32'(bus.busy), 32'd0);
        strobe_edges.delete();
`ifdef INSTR_DISPATCHER_STATS_EN
        check("stats_issued", issued_count, 32'd11);
`endif

        // Reset with queued instructions discards them
        bus.unit_busy = 3'b001;
        for (int i = 0; i < 3; i++) push_one(mk(8'h08, 16'h6000 + 16'(i)), acc);
        check("s6_pending", 32'(bus.idle), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("s6_idle", 32'(bus.idle), 32'd1);
        check("s6_busy", 32'(bus.busy), 32'd0);
        check("s6_unit_instr", 32'(bus.unit_instr), 32'(INIT_INSTR));
        check("s6_strobe", 32'(bus.unit_instr_enable), 32'd0);
`ifdef INSTR_DISPATCHER_STATS_EN
        check("stats_reset", issued_count, 32'd0);
`endif
        bus.unit_busy = 3'b000;
        repeat (4) tick();
        check("s6_discarded", 32'(strobe_edges.size()), 32'd0);

        // NOP pops in one cycle with no strobe
        push_one(mk(8'h00, 16'h7777), acc);
        check("nop_queued", 32'(bus.idle), 32'd0);
        tick();
        check("nop_popped", 32'(bus.idle), 32'd1);
        repeat (3) tick();
        check("nop_no_strobe", 32'(strobe_edges.size()), 32'd0);
        check("nop_no_sync", 32'(sync_edges.size()), 32'd0);
        check("nop_unit_instr", 32'(bus.unit_instr), 32'(INIT_INSTR));
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
